// File: rtl/fet_pkg.sv
// ============================================================================
// fet_pkg : shared fetch-unit types and constants (FSM states, NOP, reset PC)
// Revision: 1.0
// ============================================================================
`default_nettype none

package fet_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FULL   = 2'd1,
    ST_HALTED = 2'd2
  } fet_state_e;

  localparam logic [31:0] FET_NOP        = 32'h0000_0033;
  localparam logic [31:0] FET_RESET_ADDR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fet_fifo.sv
// ============================================================================
// fet_fifo : circular prefetch queue with synchronous flush and occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module fet_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fet_pq.sv
// ============================================================================
// fet_pq : instruction prefetch queue; optional misaligned-redirect trap via
//          macro FET_MISALIGN_TRAP_EN (adds port o_trap)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fet_pq
  import fet_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(FET_RESET_ADDR)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_ren,
  output logic [XLEN-1:0] o_imem_raddr,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_halt,
  input  logic            i_rdy,
  output logic            o_vld,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
`ifdef FET_MISALIGN_TRAP_EN
  output logic            o_trap,
`endif
  output logic [XLEN-1:0] o_nxt_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN;

  fet_state_e      state;
  fet_state_e      state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] redir_tgt;
  logic            inflight;
  logic            misalign;
  logic            ren;
  logic            push;
  logic            pop;
  logic            empty;
  logic [CW-1:0]   count;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   occ_nxt;
  logic [EW-1:0]   head;

`ifdef FET_MISALIGN_TRAP_EN
  logic trap;

  assign misalign  = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign redir_tgt = i_redirect_pc;
  assign o_trap    = trap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      trap <= 1'b0;
    end else if (misalign) begin
      trap <= 1'b1;
    end
  end
`else
  assign misalign  = 1'b0;
  assign redir_tgt = i_redirect_pc & ~XLEN'(3);
`endif

  // A redirect kills both the queue contents and the response in flight.
  assign push      = inflight && !i_redirect;
  assign pop       = o_vld && i_rdy && !i_redirect;
  assign occ       = count + CW'(inflight);
  assign count_nxt = i_redirect ? '0 : (count + CW'(push) - CW'(pop));
  assign occ_nxt   = count_nxt + CW'(ren && !i_redirect);

  fet_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({i_imem_rdata, req_addr}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_HALTED || i_halt || misalign) begin
      state_nxt = ST_HALTED;
    end else if (occ_nxt == CW'(DEPTH)) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // Halt stops issue in the same cycle so only already-launched work drains.
  always_comb begin
    ren = 1'b0;
    if (state == ST_RUN && !i_rst && !i_halt && occ < CW'(DEPTH)) begin
      ren = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc <= RESET_ADDR;
      req_addr <= RESET_ADDR;
      last_pc  <= RESET_ADDR;
      inflight <= 1'b0;
    end else begin
      inflight <= ren && !i_redirect;
      if (ren) begin
        req_addr <= fetch_pc;
      end
      if (i_redirect) begin
        fetch_pc <= redir_tgt;
      end else if (ren) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (o_vld) begin
        last_pc <= head[XLEN-1:0];
      end
    end
  end

  assign o_imem_ren   = ren;
  assign o_imem_raddr = fetch_pc;
  assign o_vld        = !empty;
  assign o_inst       = o_vld ? head[EW-1:XLEN] : XLEN'(FET_NOP);
  assign o_pc         = o_vld ? head[XLEN-1:0] : last_pc;
  assign o_nxt_pc     = o_pc + XLEN'(4);

endmodule

`default_nettype wire

// File: tb/tb_fet_pq.sv
// ============================================================================
// tb_fet_pq : directed self-checking bench for fet_pq with output scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fet_pq;
  import fet_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        rdy;
  logic        vld;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] nxt_pc;
`ifdef FET_MISALIGN_TRAP_EN
  logic        trap;
`endif

  int          checks = 0;
  int          errors = 0;
  int          nv;
  logic [31:0] sb [$];

  fet_pq #(
    .XLEN       (32),
    .DEPTH      (4),
    .RESET_ADDR (32'h0000_0000)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_ren    (ren),
    .o_imem_raddr  (raddr),
    .i_imem_rdata  (rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .i_rdy         (rdy),
    .o_vld         (vld),
    .o_inst        (inst),
    .o_pc          (pc),
`ifdef FET_MISALIGN_TRAP_EN
    .o_trap        (trap),
`endif
    .o_nxt_pc      (nxt_pc)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after the request with addr ^ 0xFFFF.
  always @(posedge clk) begin
    rdata <= ren ? (raddr ^ 32'h0000_FFFF) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepted outputs are compared against the scoreboard just before the edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (!rst && vld && rdy && !redirect) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed pc=%h expected=no output", pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", pc, e);
        chk("sb_inst", inst, e ^ 32'h0000_FFFF);
        chk("sb_nxt_pc", nxt_pc, e + 32'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic start_rdy);
    rst = 1'b1; rdy = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    tick();
    tick();
    sb.delete();
    rst = 1'b0;
    rdy = start_rdy;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    tick();
    tick();
    #1;
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_inst", inst, FET_NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_nxt_pc", nxt_pc, 32'h4);

    // Stream after reset: first output in cycle 2, pcs 0,4,8.
    rst = 1'b0; rdy = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    #1;
    chk("t1_ren0", 32'(ren), 32'd1);
    chk("t1_raddr0", raddr, 32'h0);
    chk("t1_vld0", 32'(vld), 32'd0);
    tick(); #1;
    chk("t1_vld1", 32'(vld), 32'd0);
    chk("t1_raddr1", raddr, 32'h4);
    tick(); #1;
    chk("t1_vld2", 32'(vld), 32'd1);
    chk("t1_pc2", pc, 32'h0);
    tick(); tick(); tick();
    rdy = 1'b0;
    chk("t1_drain", 32'(sb.size()), 32'd0);

    // Backpressure: four requests then stall until a pop.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_ren", 32'(ren), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk("t2_raddr", raddr, 32'(4 * i));
      tick();
    end
    rdy = 1'b1;
    sb.push_back(32'h0);
    #1;
    chk("t2_full_ren", 32'(ren), 32'd0);
    tick();
    rdy = 1'b0;
    #1;
    chk("t2_resume_ren", 32'(ren), 32'd1);
    chk("t2_resume_raddr", raddr, 32'h10);

    // Redirect with 3 queued + 1 in flight.
    do_reset(1'b0);
    tick(); tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    sb.delete(); sb.push_back(32'h100); sb.push_back(32'h104);
    #1;
    chk("t3_full_ren", 32'(ren), 32'd0);
    tick();
    redirect = 1'b0; rdy = 1'b1;
    #1;
    chk("t3_vld1", 32'(vld), 32'd0);
    chk("t3_ren1", 32'(ren), 32'd1);
    chk("t3_raddr1", raddr, 32'h100);
    tick(); #1;
    chk("t3_vld2", 32'(vld), 32'd0);
    tick(); #1;
    chk("t3_vld3", 32'(vld), 32'd1);
    chk("t3_pc3", pc, 32'h100);
    tick(); tick();
    rdy = 1'b0;
    chk("t3_drain", 32'(sb.size()), 32'd0);

    // Redirect coinciding with a pop: the popped entry is dropped.
    do_reset(1'b1);
    sb.push_back(32'h0);
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    sb.delete(); sb.push_back(32'h40);
    #1;
    chk("t4_pc_before", pc, 32'h4);
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_vld1", 32'(vld), 32'd0);
    chk("t4_raddr1", raddr, 32'h40);
    tick(); #1;
    chk("t4_vld2", 32'(vld), 32'd0);
    tick(); #1;
    chk("t4_vld3", 32'(vld), 32'd1);
    chk("t4_pc3", pc, 32'h40);
    tick();
    rdy = 1'b0;
    chk("t4_drain", 32'(sb.size()), 32'd0);

    // Halt with 2 queued + 1 in flight drains exactly 3.
    do_reset(1'b0);
    tick(); tick(); tick();
    halt = 1'b1;
    #1;
    chk("t5_halt_ren", 32'(ren), 32'd0);
    tick();
    halt = 1'b0; rdy = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t5_ren", 32'(ren), 32'd0);
      if (i == 3) begin
        chk("t5_hold_vld", 32'(vld), 32'd0);
        chk("t5_hold_pc", pc, 32'h8);
        chk("t5_hold_nxt", nxt_pc, 32'hC);
        chk("t5_hold_inst", inst, FET_NOP);
      end
      nv += int'(vld);
      tick();
    end
    chk("t5_drained", 32'(nv), 32'd3);
    chk("t5_drain", 32'(sb.size()), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    #1;
    chk("t5_halt_raddr", raddr, 32'h200);
    chk("t5_halt_ren2", 32'(ren), 32'd0);
    tick(); #1;
    chk("t5_halt_ren3", 32'(ren), 32'd0);
    chk("t5_halt_vld3", 32'(vld), 32'd0);

    // Misaligned redirect target.
    do_reset(1'b1);
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h102;
    sb.delete();
`ifdef FET_MISALIGN_TRAP_EN
    #1;
    chk("t6_trap0", 32'(trap), 32'd0);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_trap", 32'(trap), 32'd1);
      chk("t6_ren", 32'(ren), 32'd0);
      chk("t6_vld", 32'(vld), 32'd0);
      tick();
    end
`else
    sb.push_back(32'h100); sb.push_back(32'h104);
    tick();
    redirect = 1'b0;
    #1;
    chk("t6_ren", 32'(ren), 32'd1);
    chk("t6_raddr", raddr, 32'h100);
    tick(); tick(); #1;
    chk("t6_vld", 32'(vld), 32'd1);
    chk("t6_pc", pc, 32'h100);
    tick(); tick();
    rdy = 1'b0;
    chk("t6_drain", 32'(sb.size()), 32'd0);
`endif

    // Fetch PC and o_nxt_pc wrap at 2^32.
    do_reset(1'b1);
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    sb.delete(); sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t7_raddr0", raddr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("t7_raddr1", raddr, 32'h0);
    tick(); #1;
    chk("t7_pc", pc, 32'hFFFF_FFFC);
    chk("t7_nxt_pc", nxt_pc, 32'h0);
    tick(); tick();
    rdy = 1'b0;
    chk("t7_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
